// File: rtl/fta_io_arbiter.sv
// Round-robin arbiter sharing the 128-bit I/O bridge slave port between NREQ masters.
// One transaction outstanding at a time; a silent device is answered with a synthesised error.

package fta_io_pkg;

    typedef struct packed {
        logic         cyc;
        logic         stb;
        logic         we;
        logic [15:0]  sel;
        logic [3:0]   cid;
        logic [7:0]   tid;
        logic [31:0]  padr;
        logic [127:0] dat;
    } fta_cmd_request128_t;

    typedef struct packed {
        logic         ack;
        logic         err;
        logic         stall;
        logic         next;
        logic [3:0]   cid;
        logic [7:0]   tid;
        logic [127:0] dat;
    } fta_cmd_response128_t;

endpackage

// Per-requester response register: carries a response for exactly one cycle, zero otherwise.
module fta_io_arb_lane
    import fta_io_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 load,
    input  fta_cmd_response128_t resp_d,
    output fta_cmd_response128_t resp_q
);

    always_ff @(posedge clk_i) begin
        if (!rst_ni)
            resp_q <= '0;
        else
            resp_q <= load ? resp_d : '0;
    end

endmodule

module fta_io_arbiter
    import fta_io_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 1023
)(
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  fta_cmd_request128_t  [NREQ-1:0]      req_i,
    output logic                 [NREQ-1:0]      gnt_o,
    output fta_cmd_response128_t [NREQ-1:0]      resp_o,
    output fta_cmd_request128_t                  m_req_o,
    input  fta_cmd_response128_t                 m_resp_i,
    output logic                                 busy_o,
    output logic                                 stray_o,
    output logic                                 tmo_o
);

    localparam int         IW       = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [9:0] TMO_LAST = 10'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t               state, state_nxt;
    logic [IW-1:0]        rr_ptr;
    logic [IW-1:0]        cap_idx;
    logic [3:0]           cap_cid;
    logic [7:0]           cap_tid;
    logic [9:0]           tmo_cnt;

    logic [NREQ-1:0]      cyc_vec;
    logic                 win_vld;
    logic [IW-1:0]        win_idx;
    int                   scan_j;
    fta_cmd_request128_t  win_req;

    logic                 rsp_hit;
    logic                 match;
    logic                 tmo_hit;
    logic                 do_grant;
    logic                 do_done;
    logic                 do_tmo;
    logic                 do_stray;
    fta_cmd_response128_t resp_d;

    function automatic fta_cmd_request128_t req_idle();
        fta_cmd_request128_t r;
        r      = '0;
        r.padr = '1;
        return r;
    endfunction

    for (genvar n = 0; n < NREQ; n++) begin : g_cyc
        assign cyc_vec[n] = req_i[n].cyc;
    end

    // Scan from rr_ptr+1 upward; iterating farthest-first lets the nearest requester overwrite.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        scan_j  = 0;
        for (int i = NREQ; i >= 1; i--) begin
            scan_j = (int'(rr_ptr) + i) % NREQ;
            if (cyc_vec[IW'(scan_j)]) begin
                win_vld = 1'b1;
                win_idx = IW'(scan_j);
            end
        end
    end

    always_comb begin
        win_req     = req_i[win_idx];
        win_req.cyc = 1'b1;
        win_req.stb = 1'b1;
    end

    assign rsp_hit = m_resp_i.ack | m_resp_i.err;
    assign match   = (state == WAIT) && rsp_hit && (m_resp_i.tid == cap_tid);
    assign tmo_hit = (state == WAIT) && !match && (tmo_cnt == TMO_LAST);

    // FSM: state register
    always_ff @(posedge clk_i) begin
        if (!rst_ni)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (win_vld) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (match || tmo_hit) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM: per-cycle actions
    always_comb begin
        do_grant = (state == IDLE) && win_vld;
        do_done  = match;
        do_tmo   = tmo_hit;
        do_stray = rsp_hit && !match;
    end

    always_comb begin
        resp_d = m_resp_i;
        if (do_tmo) begin
            resp_d     = '0;
            resp_d.err = 1'b1;
            resp_d.cid = cap_cid;
            resp_d.tid = cap_tid;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rr_ptr  <= IW'(NREQ - 1);
            cap_idx <= '0;
            cap_cid <= '0;
            cap_tid <= '0;
            tmo_cnt <= '0;
            m_req_o <= req_idle();
            gnt_o   <= '0;
            busy_o  <= 1'b0;
            stray_o <= 1'b0;
            tmo_o   <= 1'b0;
        end else begin
            gnt_o   <= do_grant ? (NREQ'(1) << win_idx) : '0;
            stray_o <= do_stray;
            tmo_o   <= do_tmo;
            if (do_grant) begin
                cap_idx <= win_idx;
                cap_cid <= win_req.cid;
                cap_tid <= win_req.tid;
                rr_ptr  <= win_idx;
                m_req_o <= win_req;
                busy_o  <= 1'b1;
            end else if (state == ISSUE) begin
                m_req_o <= req_idle();
                tmo_cnt <= '0;
            end else if (state == WAIT) begin
                if (do_done || do_tmo)
                    busy_o <= 1'b0;
                else
                    tmo_cnt <= tmo_cnt + 10'd1;
            end
        end
    end

    for (genvar n = 0; n < NREQ; n++) begin : g_lane
        fta_io_arb_lane u_lane (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .load   ((do_done || do_tmo) && (cap_idx == IW'(n))),
            .resp_d (resp_d),
            .resp_q (resp_o[n])
        );
    end

endmodule

// File: tb/tb_fta_io_arbiter.sv
// Directed and randomised checks of fta_io_arbiter (NREQ=4, TIMEOUT=16) against
// a round-robin reference model held in the bench.

module tb_fta_io_arbiter;
    import fta_io_pkg::*;

    localparam int NREQ = 4;
    localparam int TMO  = 16;

    logic                               clk_i = 1'b0;
    logic                               rst_ni;
    fta_cmd_request128_t  [NREQ-1:0]    req_i;
    logic                 [NREQ-1:0]    gnt_o;
    fta_cmd_response128_t [NREQ-1:0]    resp_o;
    fta_cmd_request128_t                m_req_o;
    fta_cmd_response128_t               m_resp_i;
    logic                               busy_o;
    logic                               stray_o;
    logic                               tmo_o;

    int n_assert = 0;
    int n_fail   = 0;

    fta_io_arbiter #(.NREQ(NREQ), .TIMEOUT(TMO)) dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .req_i    (req_i),
        .gnt_o    (gnt_o),
        .resp_o   (resp_o),
        .m_req_o  (m_req_o),
        .m_resp_i (m_resp_i),
        .busy_o   (busy_o),
        .stray_o  (stray_o),
        .tmo_o    (tmo_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // idx < 0 means every lane must be zero
    task automatic chk_resp(input string tag, input int idx, input fta_cmd_response128_t exp);
        for (int n = 0; n < NREQ; n++)
            chk($sformatf("%s[%0d]", tag, n), 192'(resp_o[n]), (n == idx) ? 192'(exp) : 192'(0));
    endtask

    task automatic wait_gnt(input string tag, output int idx);
        idx = -1;
        for (int k = 0; k < 8 && idx < 0; k++) begin
            step();
            for (int n = 0; n < NREQ; n++)
                if (gnt_o[n] && idx < 0) idx = n;
        end
        chk({tag, "_seen"}, 192'(idx >= 0), 192'(1));
        if (idx >= 0) chk({tag, "_onehot"}, 192'($onehot(gnt_o)), 192'(1));
    endtask

    function automatic fta_cmd_request128_t mkreq(input int idx, input logic [7:0] tid);
        fta_cmd_request128_t r;
        r      = '0;
        r.cyc  = 1'b1;
        r.we   = 1'($urandom_range(0, 1));
        r.sel  = 16'($urandom);
        r.cid  = 4'(idx);
        r.tid  = tid;
        r.padr = $urandom;
        r.dat  = {$urandom, $urandom, $urandom, $urandom};
        return r;
    endfunction

    function automatic fta_cmd_response128_t mkrsp(input logic ack, input logic err, input logic [7:0] tid);
        fta_cmd_response128_t r;
        r      = '0;
        r.ack  = ack;
        r.err  = err;
        r.next = 1'($urandom_range(0, 1));
        r.cid  = 4'($urandom);
        r.tid  = tid;
        r.dat  = {$urandom, $urandom, $urandom, $urandom};
        return r;
    endfunction

    function automatic fta_cmd_request128_t issued(input fta_cmd_request128_t r);
        fta_cmd_request128_t x;
        x     = r;
        x.cyc = 1'b1;
        x.stb = 1'b1;
        return x;
    endfunction

    task automatic do_reset();
        rst_ni   = 1'b0;
        req_i    = '0;
        m_resp_i = '0;
        step();
        step();
        rst_ni = 1'b1;
    endtask

    fta_cmd_request128_t  ridle;
    fta_cmd_request128_t  rq;
    fta_cmd_request128_t  rqs [NREQ];
    fta_cmd_response128_t rs;
    fta_cmd_response128_t rexp;
    int                   g;
    int                   last;
    int                   expw;
    int                   lat;
    logic [NREQ-1:0]      mask;

    initial begin
        ridle      = '0;
        ridle.padr = 32'hFFFF_FFFF;

        // Reset values
        do_reset();
        chk("rst_gnt",   192'(gnt_o),   192'(0));
        chk("rst_busy",  192'(busy_o),  192'(0));
        chk("rst_stray", 192'(stray_o), 192'(0));
        chk("rst_tmo",   192'(tmo_o),   192'(0));
        chk("rst_mreq",  192'(m_req_o), 192'(ridle));
        chk_resp("rst_resp", -1, '0);

        // Single read from requester 1
        rq = mkreq(1, 8'd5);
        req_i[1] = rq;
        wait_gnt("single_gnt", g);
        chk("single_gnt_vec", 192'(gnt_o), 192'(4'b0010));
        chk("single_mreq",    192'(m_req_o), 192'(issued(rq)));
        chk("single_busy",    192'(busy_o), 192'(1));
        req_i[1].cyc = 1'b0;
        step();
        chk("single_gnt_clr", 192'(gnt_o),   192'(0));
        chk("single_mreq_idle", 192'(m_req_o), 192'(ridle));
        step();
        rs = mkrsp(1'b1, 1'b0, 8'd5);
        m_resp_i = rs;
        step();
        m_resp_i = '0;
        chk_resp("single_resp", 1, rs);
        chk("single_busy_end", 192'(busy_o), 192'(0));
        step();
        chk_resp("single_resp_clr", -1, '0);

        // Fairness: all four hold cyc continuously
        do_reset();
        for (int n = 0; n < NREQ; n++) begin
            rqs[n]   = mkreq(n, 8'(8'h20 + n));
            req_i[n] = rqs[n];
        end
        for (int i = 0; i < 5; i++) begin
            wait_gnt($sformatf("fair_gnt%0d", i), g);
            chk($sformatf("fair_order%0d", i), 192'(g), 192'(i % NREQ));
            if (i == 4) req_i = '0;
            step();
            if (g >= 0) begin
                rs = mkrsp(1'b1, 1'b0, rqs[g].tid);
                m_resp_i = rs;
                step();
                m_resp_i = '0;
                chk_resp($sformatf("fair_resp%0d", i), g, rs);
            end
        end

        // Timeout on requester 2 then a late ack
        rq = mkreq(2, 8'd9);
        req_i[2] = rq;
        wait_gnt("tmo_gnt", g);
        chk("tmo_gnt_idx", 192'(g), 192'(2));
        req_i[2].cyc = 1'b0;
        for (int k = 1; k < 17; k++) begin
            step();
            chk($sformatf("tmo_early%0d", k), 192'({tmo_o, resp_o[2].err}), 192'(0));
        end
        step();
        rexp     = '0;
        rexp.err = 1'b1;
        rexp.cid = 4'd2;
        rexp.tid = 8'd9;
        chk_resp("tmo_resp", 2, rexp);
        chk("tmo_pulse", 192'(tmo_o),  192'(1));
        chk("tmo_busy",  192'(busy_o), 192'(0));
        step();
        chk("tmo_pulse_clr", 192'(tmo_o), 192'(0));
        m_resp_i = mkrsp(1'b1, 1'b0, 8'd9);
        step();
        m_resp_i = '0;
        chk("tmo_late_stray", 192'(stray_o), 192'(1));
        chk_resp("tmo_late_resp", -1, '0);

        // Race: matching ack on the expiry cycle wins
        rq = mkreq(1, 8'h11);
        req_i[1] = rq;
        wait_gnt("race_gnt", g);
        chk("race_gnt_idx", 192'(g), 192'(1));
        req_i[1].cyc = 1'b0;
        repeat (16) step();
        rs = mkrsp(1'b1, 1'b0, 8'h11);
        m_resp_i = rs;
        step();
        m_resp_i = '0;
        chk_resp("race_resp", 1, rs);
        chk("race_tmo",   192'(tmo_o),   192'(0));
        chk("race_stray", 192'(stray_o), 192'(0));
        step();
        chk("race_tmo_after", 192'(tmo_o), 192'(0));

        // Tid mismatch is dropped, matching tid delivered
        rq = mkreq(3, 8'd7);
        req_i[3] = rq;
        wait_gnt("stray_gnt", g);
        chk("stray_gnt_idx", 192'(g), 192'(3));
        req_i[3].cyc = 1'b0;
        step();
        m_resp_i = mkrsp(1'b1, 1'b0, 8'd3);
        step();
        chk("stray_pulse", 192'(stray_o), 192'(1));
        chk("stray_busy",  192'(busy_o),  192'(1));
        chk_resp("stray_noresp", -1, '0);
        rs = mkrsp(1'b1, 1'b0, 8'd7);
        m_resp_i = rs;
        step();
        m_resp_i = '0;
        chk("stray_match_nopulse", 192'(stray_o), 192'(0));
        chk_resp("stray_match_resp", 3, rs);
        m_resp_i = mkrsp(1'b0, 1'b1, 8'd7);
        step();
        m_resp_i = '0;
        chk("stray_idle_pulse", 192'(stray_o), 192'(1));

        // Reset during WAIT abandons the transaction
        rq = mkreq(0, 8'd4);
        req_i[0] = rq;
        wait_gnt("rstop_gnt", g);
        req_i[0].cyc = 1'b0;
        step();
        rst_ni = 1'b0;
        step();
        rst_ni = 1'b1;
        chk("rstop_gnt",  192'(gnt_o),   192'(0));
        chk("rstop_busy", 192'(busy_o),  192'(0));
        chk("rstop_mreq", 192'(m_req_o), 192'(ridle));
        chk("rstop_flags", 192'({stray_o, tmo_o}), 192'(0));
        chk_resp("rstop_resp", -1, '0);
        m_resp_i = mkrsp(1'b1, 1'b0, 8'd4);
        step();
        m_resp_i = '0;
        chk("rstop_stray", 192'(stray_o), 192'(1));
        chk_resp("rstop_noresp", -1, '0);

        // Randomised traffic against the round-robin model
        do_reset();
        last = NREQ - 1;
        mask = '0;
        for (int r = 0; r < 40; r++) begin
            for (int n = 0; n < NREQ; n++)
                if (!mask[n] && $urandom_range(0, 2) == 0) begin
                    rqs[n]   = mkreq(n, 8'($urandom));
                    req_i[n] = rqs[n];
                    mask[n]  = 1'b1;
                end
            if (mask == '0) begin
                g        = $urandom_range(0, NREQ - 1);
                rqs[g]   = mkreq(g, 8'($urandom));
                req_i[g] = rqs[g];
                mask[g]  = 1'b1;
            end
            expw = -1;
            for (int k = 1; k <= NREQ; k++)
                if (expw < 0 && mask[(last + k) % NREQ]) expw = (last + k) % NREQ;
            wait_gnt($sformatf("rnd_gnt%0d", r), g);
            chk($sformatf("rnd_pick%0d", r), 192'(g), 192'(expw));
            chk($sformatf("rnd_mreq%0d", r), 192'(m_req_o), 192'(issued(rqs[expw])));
            req_i[expw].cyc = 1'b0;
            mask[expw]      = 1'b0;
            last            = expw;
            lat = $urandom_range(1, 5);
            repeat (lat) step();
            rs = mkrsp(1'($urandom_range(0, 1)), 1'b0, rqs[expw].tid);
            if (!rs.ack) rs.err = 1'b1;
            m_resp_i = rs;
            step();
            m_resp_i = '0;
            chk_resp($sformatf("rnd_resp%0d", r), expw, rs);
            chk($sformatf("rnd_busy%0d", r), 192'(busy_o), 192'(0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
